fetch_unit: RTL and testbench

Instruction-fetch stage of the SISC processor, directly upstream of the control FSM. Holds the program counter and instruction register, runs a request/acknowledge read against instruction memory when the FSM enters fetch, and presents `opcode`/`mm` fields to the FSM. It also resolves branch instructions (BRA, BRR, BNE, BNR) against the status flags when the FSM asserts branch evaluation in execute.

---
 rtl/sisc_pkg.sv | 28 ++
 rtl/fetch_unit_br_target.sv | 43 ++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, fetch FSM states, instruction fields.
// Imported by the fetch stage and its branch resolver.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_ALU  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_br_target.sv
// Branch resolver: decides whether the IR branch is taken and where to.
// Relative targets are added to the already-incremented pc.
module br_target
    import sisc_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [3:0]      opcode,
    input  logic [3:0]      mm,
    input  logic [3:0]      stat,
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     ir_imm,
    output logic            take,
    output logic [PC_W-1:0] target
);

    logic            hit;
    logic [PC_W-1:0] abs_t;
    logic [PC_W-1:0] rel_t;

    assign hit   = |(mm & stat);
    assign abs_t = PC_W'(ir_imm);
    assign rel_t = pc + PC_W'($signed(ir_imm));

    always_comb begin
        take   = 1'b0;
        target = abs_t;
        unique case (opcode)
            OP_BRA: take = hit;
            OP_BRR: begin
                take   = hit;
                target = rel_t;
            end
            OP_BNE: take = !hit;
            OP_BNR: begin
                take   = !hit;
                target = rel_t;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// SISC instruction fetch stage: PC/IR, req/ack memory read with timeout,
// and branch resolution on request from the control FSM.
module fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_start,
    input  logic               br_eval,
    input  logic [3:0]         stat,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [PC_W-1:0]    pc,
    output logic               fetch_done,
    output logic               fetch_busy,
    output logic               fetch_err,
    output logic               halted
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               halted_q, halted_d;
    logic               br_take;
    logic [PC_W-1:0]    br_tgt;

    br_target #(
        .PC_W(PC_W)
    ) u_br_target (
        .opcode (ir_q[OPC_HI:OPC_LO]),
        .mm     (ir_q[MM_HI:MM_LO]),
        .stat   (stat),
        .pc     (pc_q),
        .ir_imm (ir_q[IMM_HI:IMM_LO]),
        .take   (br_take),
        .target (br_tgt)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        halted_d = halted_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // A same-cycle branch lands in pc_q, so the request uses it
                if (br_eval && br_take) pc_d = br_tgt;
                if (fetch_start && !halted_q) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (imem_rdata[OPC_HI:OPC_LO] == OP_HLT) halted_d = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req   = (state_q == ST_BUSY);
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == ST_BUSY);
    assign fetch_err  = (state_q == ST_ERR);
    assign fetch_done = done_q;
    assign halted     = halted_q;
    assign ir         = ir_q;
    assign opcode     = ir_q[OPC_HI:OPC_LO];
    assign mm         = ir_q[MM_HI:MM_LO];
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan plus random fetch/branch traffic
// against a simple pc/ir/halt model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_start;
    logic        br_eval;
    logic [3:0]  stat;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] pc;
    logic        fetch_done;
    logic        fetch_busy;
    logic        fetch_err;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic        m_halt;

    fetch_unit #(
        .PC_W(16), .INSTR_W(32), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_f(rst_f), .fetch_start(fetch_start),
        .br_eval(br_eval), .stat(stat), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode), .mm(mm),
        .pc(pc), .fetch_done(fetch_done), .fetch_busy(fetch_busy),
        .fetch_err(fetch_err), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Branch outcome from the ISA rules; 16-bit wraparound makes
    // sign-extended and plain addition of the offset identical.
    function automatic logic [15:0] exp_branch(input logic [31:0] i,
                                               input logic [3:0] s,
                                               input logic [15:0] p);
        logic hit;
        logic [15:0] rel;
        hit = (i[27:24] & s) != 4'd0;
        rel = p + i[15:0];
        case (i[31:28])
            4'd4: return hit ? i[15:0] : p;
            4'd5: return hit ? rel : p;
            4'd6: return hit ? p : i[15:0];
            4'd7: return hit ? p : rel;
            default: return p;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_f = 1'b1;
        fetch_start = 0; br_eval = 0; imem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ir", ir, 0);
        chk("rst_flags", {27'd0, imem_req, fetch_done, fetch_busy,
                          fetch_err, halted}, 0);
        rst_f = 1'b0;
        m_pc = 0; m_ir = 0; m_halt = 0;
    endtask

    // One fetch; optional same-cycle branch, optional ignored strobes
    // while the request is outstanding.
    task automatic do_fetch(input logic [31:0] word, input int wait_n,
                            input bit with_br, input logic [3:0] s,
                            input bit disturb);
        fetch_start = 1'b1;
        br_eval = with_br;
        stat = s;
        if (with_br) m_pc = exp_branch(m_ir, s, m_pc);
        @(negedge clk);
        fetch_start = 0; br_eval = 0;
        chk("req_rise", 32'(imem_req), 1);
        chk("req_addr", 32'(imem_addr), 32'(m_pc));
        for (int i = 0; i < wait_n; i++) begin
            if (disturb && i == 0) begin
                fetch_start = 1'b1; br_eval = 1'b1;
                stat = 4'hF;
            end
            @(negedge clk);
            fetch_start = 0; br_eval = 0;
            chk("req_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, m_pc});
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        m_ir = word;
        m_pc = m_pc + 16'd1;
        if (word[31:28] == 4'hF) m_halt = 1'b1;
        chk("done", 32'(fetch_done), 1);
        chk("ir", ir, m_ir);
        chk("op_mm", {24'd0, opcode, mm}, {24'd0, m_ir[31:24]});
        chk("pc_inc", 32'(pc), 32'(m_pc));
        chk("halted", 32'(halted), 32'(m_halt));
        @(negedge clk);
        chk("done_once", {30'd0, fetch_done, imem_req}, 0);
    endtask

    task automatic do_branch(input logic [3:0] s);
        br_eval = 1'b1;
        stat = s;
        m_pc = exp_branch(m_ir, s, m_pc);
        @(negedge clk);
        br_eval = 1'b0;
        chk("br_pc", 32'(pc), 32'(m_pc));
        chk("br_idle", 32'(fetch_busy), 0);
    endtask

    initial begin
        int n;
        logic [31:0] w;
        rst_f = 1; fetch_start = 0; br_eval = 0; stat = 0;
        imem_ack = 0; imem_rdata = 0;
        m_pc = 0; m_ir = 0; m_halt = 0;
        do_reset();

        do_fetch(32'h1123_0004, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_fetch(32'h0, 0, 0, 0, 0);
        do_fetch(32'h5100_FFFE, 1, 0, 0, 0);
        chk("pc5", 32'(pc), 5);
        do_branch(4'b0001);
        chk("brr_taken", 32'(pc), 3);
        do_fetch(32'h0, 0, 0, 0, 0);
        do_fetch(32'h5100_FFFE, 0, 0, 0, 0);
        do_branch(4'b0000);
        chk("brr_not", 32'(pc), 5);
        do_fetch(32'h6400_0020, 0, 0, 0, 0);
        do_branch(4'b0100);
        chk("bne_not", 32'(pc), 6);
        do_branch(4'b0000);
        chk("bne_taken", 32'(pc), 32'h20);

        do_fetch(32'h4100_FFFF, 0, 0, 0, 0);
        do_branch(4'b0001);
        chk("pc_ffff", 32'(pc), 32'hFFFF);
        do_fetch(32'h0, 3, 0, 0, 1);
        chk("pc_wrap", 32'(pc), 0);
        do_fetch(32'h4100_0040, 0, 0, 0, 0);
        do_fetch(32'h0, 0, 1, 4'b0001, 0);
        chk("sim_br", 32'(pc), 32'h41);

        for (int k = 0; k < 60; k++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1)
                w[31:28] = 4'(4 + $urandom_range(0, 3));
            else
                w[31:28] = 4'($urandom_range(0, 14));
            case ($urandom_range(0, 2))
                0: do_fetch(w, $urandom_range(0, 14), 0, 0,
                            1'($urandom_range(0, 1)));
                1: do_fetch(w, $urandom_range(0, 4), 1,
                            4'($urandom), 0);
                default: do_branch(4'($urandom));
            endcase
        end

        do_reset();
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        n = 0;
        while (imem_req && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", 32'(n), 15);
        chk("to_err", {30'd0, fetch_err, imem_req}, 32'b10);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        chk("err_sticky", {30'd0, fetch_err, imem_req}, 32'b10);

        do_reset();
        do_fetch(32'hF000_0000, 0, 0, 0, 0);
        chk("hlt", 32'(halted), 1);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        chk("hlt_noreq", {30'd0, imem_req, halted}, 32'b01);

        do_reset();
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        chk("rst_mid", 32'(imem_req), 0);
        rst_f = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack", {ir[30:0], fetch_done}, 0);
        chk("late_pc", 32'(pc), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
